// File: rtl/sm_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encoding and
// sizing constants for the port index and latency counter.
package sm_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int PORT_IDX_W  = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/sm_rr_pick2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the port that did not win last time.
module sm_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       any
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
    any = |req;
  end

endmodule

// File: rtl/sm_imem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency instruction-memory read port
// between two fetch requesters; one outstanding access at a time.
module sm_imem_arbiter
  import sm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  arb_state_e                  r_state;
  arb_state_e                  w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [PORT_IDX_W-1:0]       r_owner;
  logic                        r_last;
  logic                        r_rvalid0;
  logic                        r_rvalid1;
  logic [DATA_WIDTH-1:0]       r_rdata;

  logic [1:0]                  w_req;
  logic [1:0]                  w_win;
  logic                        w_any;
  logic                        w_busy;
  logic                        w_done;

  // Requests are only visible to the picker when a grant is legal.
  assign w_req  = {req1, req0} & {2{(r_state == ST_IDLE) && !rst}};
  assign w_busy = (r_state == ST_BUSY);
  assign w_done = w_busy && (r_cnt == CNT_W'(1));

  sm_rr_pick2 u_pick (
    .req  (w_req),
    .last (r_last),
    .win  (w_win),
    .any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0     = w_win[0];
    gnt1     = w_win[1];
    mem_en   = w_any;
    mem_addr = '0;
    if (w_win[0])      mem_addr = addr0;
    else if (w_win[1]) mem_addr = addr1;
    busy     = w_busy;
    rvalid0  = r_rvalid0;
    rvalid1  = r_rvalid1;
    rdata    = r_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_owner   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid0 <= w_done && (r_owner == 1'b0);
      r_rvalid1 <= w_done && (r_owner == 1'b1);
      if (w_any) begin
        r_cnt   <= LAT_LOAD;
        r_owner <= w_win[1];
        r_last  <= w_win[1];
      end else if (w_busy) begin
        r_cnt   <= r_cnt - CNT_W'(1);
      end
      if (w_done) r_rdata <= mem_rdata;
    end
  end

endmodule
